// File: rtl/pc_fetch_pkg.sv
// ============================================================================
// Module : pc_fetch_pkg
// Brief  : Shared constants, state encodings and next-PC helper for pc_fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

    localparam logic [31:0] c_PC_RESET_VECTOR = 32'hBFC00000;
    localparam int          c_INST_W          = 32;

    localparam logic [1:0] c_S_BOOT  = 2'd0;
    localparam logic [1:0] c_S_FETCH = 2'd1;
    localparam logic [1:0] c_S_HOLD  = 2'd2;

    // Advancing-cycle target: taken branch wins over sequential, +4 wraps mod 2^32.
    function automatic logic [31:0] f_pc_next(
        input logic [31:0] pc,
        input logic        branch,
        input logic [31:0] target
    );
        return branch ? target : (pc + 32'd4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// Module : pc_fetch
// Brief  : Program counter and instruction-bus fetch master feeding IF/ID.
//          Optional misaligned-fetch detection enabled by PC_ALIGN_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_PC_RESET_VECTOR,
    parameter int          INST_W       = c_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              flush,
    input  logic [31:0]       new_pc,
    input  logic              branch_flag_i,
    input  logic [31:0]       branch_target_address_i,
    input  logic              ibus_ack_i,
    input  logic [INST_W-1:0] ibus_data_i,
    output logic              ibus_req_o,
    output logic [31:0]       ibus_addr_o,
    output logic [31:0]       pc,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stallreq_from_pc,
    output logic              pc_adel_o
);

    logic [1:0]        r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_pend_pc;
    logic              r_flush_pend;
    logic [INST_W-1:0] r_inst;
    logic              r_inst_valid;
    logic              w_req;
    logic              w_unused_stall;

    assign w_unused_stall = &{1'b0, stall[5:1]};

`ifdef PC_ALIGN_CHECK_EN
    logic r_adel;
    logic w_misaligned;

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_req        = (r_state == c_S_FETCH) && !w_misaligned;
    assign pc_adel_o    = r_adel;
`else
    assign w_req        = (r_state == c_S_FETCH);
    assign pc_adel_o    = 1'b0;
`endif

    assign ibus_req_o       = w_req;
    assign ibus_addr_o      = r_pc;
    assign pc               = r_pc;
    assign inst_o           = r_inst;
    assign inst_valid_o     = r_inst_valid;
    assign stallreq_from_pc = w_req && !ibus_ack_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_BOOT;
            r_pc         <= RESET_VECTOR;
            r_pend_pc    <= 32'd0;
            r_flush_pend <= 1'b0;
            r_inst       <= '0;
            r_inst_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            r_adel       <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_S_BOOT: begin
                    r_state <= c_S_FETCH;
                end

                c_S_FETCH: begin
`ifdef PC_ALIGN_CHECK_EN
                    // Misaligned PC never reaches the bus; emit one NOP and park until redirected.
                    if (w_misaligned) begin
                        if (flush) begin
                            r_pc         <= new_pc;
                            r_adel       <= 1'b0;
                            r_inst_valid <= 1'b0;
                        end else begin
                            r_inst       <= '0;
                            r_inst_valid <= !r_adel;
                            r_adel       <= 1'b1;
                        end
                    end else
`endif
                    if (ibus_ack_i) begin
                        if (flush || r_flush_pend) begin
                            r_inst_valid <= 1'b0;
                            r_pc         <= flush ? new_pc : r_pend_pc;
                            r_flush_pend <= 1'b0;
                        end else begin
                            r_inst       <= ibus_data_i;
                            r_inst_valid <= 1'b1;
                            if (stall[0]) begin
                                r_state <= c_S_HOLD;
                            end else begin
                                r_pc <= f_pc_next(r_pc, branch_flag_i, branch_target_address_i);
                            end
                        end
                    end else begin
                        // Request must stay up until ack; remember the redirect for then.
                        r_inst_valid <= 1'b0;
                        if (flush) begin
                            r_flush_pend <= 1'b1;
                            r_pend_pc    <= new_pc;
                        end
                    end
                end

                c_S_HOLD: begin
                    if (flush) begin
                        r_pc         <= new_pc;
                        r_inst_valid <= 1'b0;
                        r_state      <= c_S_FETCH;
                    end else if (!stall[0]) begin
                        r_pc    <= f_pc_next(r_pc, branch_flag_i, branch_target_address_i);
                        r_state <= c_S_FETCH;
                    end
                end

                default: begin
                    r_state <= c_S_BOOT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
